// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads the word at the current PC over a req/ack memory handshake,
// latches it into ir, and drives the PC register with the sequential address or a redirect.
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int PC_INC  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              busy,
  output logic              fetch_err
);

  // state  | meaning
  // IDLE   | waiting for fetch_start; applies immediate or pending redirects to the PC
  // REQ    | memory request outstanding at addr_reg; timeout counter running
  // LOAD   | one cycle: load PC with sequential address or redirect, pulse ir_valid

  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] redir_addr;
  logic              redir_pend;
  logic [TCNT_W-1:0] tcnt;
  logic              tcnt_tc;

  assign tcnt_tc = (tcnt == TCNT_W'(TIMEOUT - 1));
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_addr = '0;
    ir_valid = 1'b0;
    pc_load  = 1'b0;
    pc_next  = '0;
    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          pc_next = redirect_addr;
        end else if (redir_pend) begin
          pc_load = 1'b1;
          pc_next = redir_addr;
        end else if (fetch_start && !fetch_err) begin
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = addr_reg;
        if (mem_ack)      state_nx = S_LOAD;
        else if (tcnt_tc) state_nx = S_IDLE;
      end
      S_LOAD: begin
        pc_load  = 1'b1;
        state_nx = S_IDLE;
        if (redirect_valid) begin
          pc_next = redirect_addr;
        end else if (redir_pend) begin
          pc_next = redir_addr;
        end else begin
          pc_next  = addr_reg + ADDR_W'(PC_INC);
          ir_valid = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_reg   <= '0;
      ir         <= '0;
      redir_pend <= 1'b0;
      redir_addr <= '0;
      tcnt       <= '0;
      fetch_err  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (!redirect_valid) begin
            if (redir_pend) begin
              redir_pend <= 1'b0;
            end else if (fetch_start && !fetch_err) begin
              addr_reg <= pc;
              tcnt     <= '0;
            end
          end
        end
        S_REQ: begin
          // Latest redirect wins; the fetched word is dropped if any redirect is seen.
          if (redirect_valid) begin
            redir_pend <= 1'b1;
            redir_addr <= redirect_addr;
          end
          if (mem_ack) begin
            if (!redir_pend && !redirect_valid) ir <= mem_rdata;
          end else if (tcnt_tc) begin
            fetch_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        S_LOAD: redir_pend <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand-written corner
// sequences (timeout, reset mid-fetch) and randomized transactions against a fetch-level model.
module tb_instr_fetch_unit;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          fetch_start;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ir;
  logic          ir_valid;
  logic          pc_load;
  logic [AW-1:0] pc_next;
  logic          busy;
  logic          fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .PC_INC(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_start(fetch_start),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_valid(ir_valid), .pc_load(pc_load), .pc_next(pc_next),
    .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          fs;
    logic [AW-1:0] pc;
    logic          rv;
    logic [AW-1:0] ra;
    logic          ack;
    logic [DW-1:0] rd;
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] ir;
    logic          irv;
    logic          pl;
    logic [AW-1:0] pn;
    logic          busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fs, input logic [15:0] p, input logic rv, input logic [15:0] ra,
                     input logic ack, input logic [15:0] rd, input logic req, input logic [15:0] addr,
                     input logic [15:0] irx, input logic irv, input logic pl, input logic [15:0] pn,
                     input logic bsy);
    vec_t v;
    v.fs = fs; v.pc = p; v.rv = rv; v.ra = ra; v.ack = ack; v.rd = rd;
    v.req = req; v.addr = addr; v.ir = irx; v.irv = irv; v.pl = pl; v.pn = pn; v.busy = bsy;
    vecs.push_back(v);
  endtask

  // Idle cycle with no stimulus: nothing but ir visible.
  task automatic add_idle(input logic [15:0] irx);
    add(0, 0, 0, 0, 0, 0, 0, 0, irx, 0, 0, 0, 0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic [AW-1:0] p, input logic rv,
                       input logic [AW-1:0] ra, input logic ack, input logic [DW-1:0] rd);
    fetch_start = fs; pc = p; redirect_valid = rv; redirect_addr = ra; mem_ack = ack; mem_rdata = rd;
  endtask

  initial begin
    int req_cycles;
    logic [DW-1:0] m_ir;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // reset state
    add_idle(16'h0000);
    // basic fetch, immediate ack
    add(1, 16'h0010, 0, 0, 0, 0,       0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 16'hA5A5,       1, 16'h0010, 16'h0000, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,              0, 0, 16'hA5A5, 1, 1, 16'h0011, 1);
    add_idle(16'hA5A5);
    // wait states: ack in cycle 4
    add(1, 16'h0020, 0, 0, 0, 0,       0, 0, 16'hA5A5, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 16'h0020, 16'hA5A5, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,              1, 16'h0020, 16'hA5A5, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,              1, 16'h0020, 16'hA5A5, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 16'h5A5A,       1, 16'h0020, 16'hA5A5, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,              0, 0, 16'h5A5A, 1, 1, 16'h0021, 1);
    add_idle(16'h5A5A);
    // wrap at top of address space
    add(1, 16'hFFFF, 0, 0, 0, 0,       0, 0, 16'h5A5A, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 16'h0F0F,       1, 16'hFFFF, 16'h5A5A, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,              0, 0, 16'h0F0F, 1, 1, 16'h0000, 1);
    add_idle(16'h0F0F);
    // redirect in REQ cycle 2, ack in cycle 3: squashed
    add(1, 16'h0040, 0, 0, 0, 0,       0, 0, 16'h0F0F, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 16'h0040, 16'h0F0F, 0, 0, 0, 1);
    add(0, 0, 1, 16'h0200, 0, 0,       1, 16'h0040, 16'h0F0F, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 16'h1234,       1, 16'h0040, 16'h0F0F, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,              0, 0, 16'h0F0F, 0, 1, 16'h0200, 1);
    add_idle(16'h0F0F);
    // redirect beats fetch_start in IDLE
    add(1, 16'h0050, 1, 16'h0300, 0, 0, 0, 0, 16'h0F0F, 0, 1, 16'h0300, 0);
    add_idle(16'h0F0F);
    // redirect during LOAD: ir already captured, ir_valid squashed
    add(1, 16'h0060, 0, 0, 0, 0,       0, 0, 16'h0F0F, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 16'h7777,       1, 16'h0060, 16'h0F0F, 0, 0, 0, 1);
    add(0, 0, 1, 16'h0400, 0, 0,       0, 0, 16'h7777, 0, 1, 16'h0400, 1);
    add_idle(16'h7777);
    // redirect in the same cycle as ack: ir not updated
    add(1, 16'h0070, 0, 0, 0, 0,       0, 0, 16'h7777, 0, 0, 0, 0);
    add(0, 0, 1, 16'h0500, 1, 16'h8888, 1, 16'h0070, 16'h7777, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,              0, 0, 16'h7777, 0, 1, 16'h0500, 1);
    add_idle(16'h7777);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) next_cyc();
      drive(vecs[i].fs, vecs[i].pc, vecs[i].rv, vecs[i].ra, vecs[i].ack, vecs[i].rd);
      #4;
      chk($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(vecs[i].req));
      chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].addr));
      chk($sformatf("v%0d ir", i),        32'(ir),        32'(vecs[i].ir));
      chk($sformatf("v%0d ir_valid", i),  32'(ir_valid),  32'(vecs[i].irv));
      chk($sformatf("v%0d pc_load", i),   32'(pc_load),   32'(vecs[i].pl));
      chk($sformatf("v%0d pc_next", i),   32'(pc_next),   32'(vecs[i].pn));
      chk($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].busy));
      chk($sformatf("v%0d fetch_err", i), 32'(fetch_err), 32'(0));
    end

    // Timeout: no ack ever
    next_cyc();
    drive(1, 16'h0100, 0, 0, 0, 0);
    req_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      next_cyc();
      drive(0, 0, 0, 0, 0, 0);
      #4;
      if (!mem_req) break;
      req_cycles++;
      chk("timeout pc_load in req", 32'(pc_load), 32'(0));
    end
    chk("timeout req cycles", 32'(req_cycles), 32'(15));
    chk("timeout fetch_err", 32'(fetch_err), 32'(1));
    chk("timeout busy", 32'(busy), 32'(0));
    chk("timeout pc_load", 32'(pc_load), 32'(0));
    next_cyc();
    drive(1, 16'h0123, 0, 0, 0, 0);
    #4;
    chk("err blocks fetch busy", 32'(busy), 32'(0));
    next_cyc();
    drive(0, 0, 0, 0, 0, 0);
    #4;
    chk("err blocks fetch mem_req", 32'(mem_req), 32'(0));
    chk("err sticky", 32'(fetch_err), 32'(1));
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    #4;
    chk("rst clears fetch_err", 32'(fetch_err), 32'(0));

    // Reset asserted during REQ
    next_cyc();
    drive(1, 16'h0200, 0, 0, 0, 0);
    next_cyc();
    drive(0, 0, 0, 0, 0, 0);
    #4;
    chk("rstreq mem_req before", 32'(mem_req), 32'(1));
    next_cyc();
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 16'hDEAD);
    next_cyc();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #4;
    chk("rstreq mem_req", 32'(mem_req), 32'(0));
    chk("rstreq busy", 32'(busy), 32'(0));
    chk("rstreq pc_load", 32'(pc_load), 32'(0));
    chk("rstreq ir", 32'(ir), 32'(0));
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      #4;
      chk("rstreq no ir_valid", 32'(ir_valid), 32'(0));
    end

    // Randomized fetches against a transaction-level model
    m_ir = '0;
    for (int t = 0; t < 150; t++) begin
      logic [AW-1:0] p, last_r, la, ra;
      logic [DW-1:0] d;
      logic any_r, lr, rv;
      int w;
      if ($urandom_range(4) == 0) begin
        ra = 16'($urandom);
        next_cyc();
        drive(1, 16'($urandom), 1, ra, 0, 0);
        #4;
        chk("rnd idle redirect pc_load", 32'(pc_load), 32'(1));
        chk("rnd idle redirect pc_next", 32'(pc_next), 32'(ra));
        next_cyc();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        chk("rnd idle redirect no req", 32'(mem_req), 32'(0));
      end
      p = 16'($urandom);
      d = 16'($urandom);
      w = $urandom_range(0, 5);
      any_r = 1'b0;
      last_r = '0;
      next_cyc();
      drive(1, p, 0, 0, 0, 0);
      #4;
      chk("rnd accept busy", 32'(busy), 32'(0));
      for (int k = 1; k <= w + 1; k++) begin
        next_cyc();
        rv = ($urandom_range(3) == 0);
        ra = 16'($urandom);
        drive(1'($urandom), 16'($urandom), rv, ra, (k == w + 1), (k == w + 1) ? d : 16'($urandom));
        if (rv) begin
          any_r = 1'b1;
          last_r = ra;
        end
        #4;
        chk("rnd req mem_req", 32'(mem_req), 32'(1));
        chk("rnd req mem_addr", 32'(mem_addr), 32'(p));
        chk("rnd req pc_load", 32'(pc_load), 32'(0));
      end
      next_cyc();
      lr = ($urandom_range(3) == 0);
      la = 16'($urandom);
      drive(0, 0, lr, la, 1'($urandom), 16'($urandom));
      if (!any_r) m_ir = d;
      #4;
      chk("rnd load pc_load", 32'(pc_load), 32'(1));
      chk("rnd load pc_next", 32'(pc_next), 32'(lr ? la : (any_r ? last_r : 16'(p + 16'd1))));
      chk("rnd load ir_valid", 32'(ir_valid), 32'(!(lr || any_r)));
      chk("rnd load ir", 32'(ir), 32'(m_ir));
      chk("rnd load mem_req", 32'(mem_req), 32'(0));
      next_cyc();
      drive(0, 0, 0, 0, 0, 0);
      #4;
      chk("rnd idle busy", 32'(busy), 32'(0));
      chk("rnd idle pc_load", 32'(pc_load), 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the multi-cycle CPU, sitting between the 16-bit program counter register and instruction memory. On a fetch command from the control FSM it reads the word at the current PC through a req/ack memory handshake and latches it as the instruction. It then drives the PC register's load and next-value inputs with the sequential address or a pending branch/jump redirect. A redirect arriving mid-fetch squashes the fetched word. A stuck memory trips a sticky timeout error.

Parameters:
ADDR_W, 16, PC / memory address width
DATA_W, 16, instruction word width
PC_INC, 1, sequential PC increment (word-addressed)
TIMEOUT, 15, max REQ cycles without mem_ack before error (>=1)

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
pc  in  ADDR_W  current value from the PC register output
fetch_start  in  1  control FSM request to fetch at pc
redirect_valid  in  1  branch/jump taken
redirect_addr  in  ADDR_W  branch/jump target
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  memory read address
mem_ack  in  1  memory read data valid this cycle
mem_rdata  in  DATA_W  memory read data
ir  out  DATA_W  latched instruction
ir_valid  out  1  one-cycle pulse, new instruction in ir
pc_load  out  1  load enable to PC register
pc_next  out  ADDR_W  data to PC register
busy  out  1  fetch in progress
fetch_err  out  1  sticky memory timeout flag

Behaviour:
- Reset (sync, highest priority): state=IDLE, addr_reg=0, ir=0, redir_pend=0, redir_addr=0, tcnt=0, fetch_err=0. Outputs are then mem_req=0, mem_addr=0, ir_valid=0, pc_load=0, pc_next=0, busy=0. rst mid-fetch aborts with no pc_load and no ir update.
- FSM states: IDLE, REQ, LOAD. busy = (state != IDLE).
- IDLE:
  - redirect_valid=1: pc_load=1 and pc_next=redirect_addr combinationally this cycle. fetch_start is ignored this cycle (redirect wins). State stays IDLE.
  - Otherwise, if redir_pend=1: pc_load=1, pc_next=redir_addr, redir_pend cleared at the edge. fetch_start is ignored this cycle.
  - Otherwise, fetch_start=1 and fetch_err=0: addr_reg<=pc, tcnt<=0, go to REQ.
- REQ:
  - mem_req=1, mem_addr=addr_reg, both stable until exit.
  - mem_ack=1 at an edge: go to LOAD. ir<=mem_rdata only if no redirect is pending or arriving that cycle.
  - No ack: tcnt increments. Timeout fires when no ack arrives at the edge where tcnt==TIMEOUT-1, i.e. at the end of the TIMEOUT-th REQ cycle. On timeout: fetch_err<=1, go to IDLE, no pc_load.
- LOAD (exactly one cycle):
  - pc_load=1.
  - If redirect_valid: pc_next=redirect_addr, ir_valid=0 (squash).
  - Else if redir_pend: pc_next=redir_addr, ir_valid=0.
  - Else: pc_next=(addr_reg+PC_INC) mod 2^ADDR_W, ir_valid=1.
  - redir_pend is cleared; state goes to IDLE.
- Redirect capture in REQ: redirect_valid sets redir_pend=1 and redir_addr=redirect_addr. The latest redirect wins.
- When pc_load=0: pc_next=0, mem_addr=0 outside REQ, ir_valid=0. ir holds its value except on a non-squashed ack.
- Latency: fetch_start accepted in cycle 0; mem_req high from cycle 1; ack in cycle N (N>=1) gives LOAD in cycle N+1. The PC register shows the new value in cycle N+2; the earliest next fetch_start is accepted in cycle N+2.
- fetch_start is ignored outside IDLE and while fetch_err=1. fetch_err clears only on rst.
- Address arithmetic wraps modulo 2^ADDR_W with no carry out.

Test Plan:
- rst, pc=0x0010, fetch_start pulse in cycle 0, mem_ack=1 with rdata=0xA5A5 in cycle 1 -> cycle 1: mem_req=1, mem_addr=0x0010. Cycle 2: ir=0xA5A5, ir_valid=1, pc_load=1, pc_next=0x0011. Cycle 3: busy=0.
- Wait states: mem_ack first asserted in cycle 4 -> mem_req=1 with mem_addr constant in cycles 1-4. ir_valid and pc_load in cycle 5 only.
- Wrap: pc=0xFFFF, immediate ack -> pc_next=0x0000 in LOAD.
- redirect_valid=1 with addr 0x0200 in cycle 2 of a REQ; ack with rdata 0x1234 in cycle 3 -> cycle 4: pc_load=1, pc_next=0x0200, ir_valid=0, ir unchanged. Also: redirect 0x0300 with fetch_start in IDLE -> same-cycle pc_load=1, pc_next=0x0300, and mem_req=0 next cycle.
- TIMEOUT=15, no ack -> mem_req=1 for exactly 15 cycles, then 0. fetch_err=1 and stays 1. A later fetch_start gives no mem_req. rst clears fetch_err.
- rst asserted during REQ -> next cycle mem_req=0, busy=0, pc_load=0, ir=0; no ir_valid pulse follows.
